pc_stack_seq: RTL

- Parametrised successor to the processor's program counter.
- Generates the instruction address for the instruction memory / instruction register and the B-bus mux.
- Adds configurable address width, a hardware return-address stack (call/return) of configurable depth, explicit async reset, a start latch and error flags.
- Sits between the control unit (which issues jump/inc/call/ret) and instruction fetch.

---
 rtl/pc_stack_pkg.sv | 24 ++
 rtl/pc_ret_stack.sv | 65 ++++++
 rtl/pc_stack_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pc_stack_pkg.sv
// Shared constants, op encoding and sizing helper for the pc_stack_seq program counter.
// Optional relative branch support is selected by PC_STACK_SEQ_REL_BRANCH_EN.
package pc_stack_pkg;

  localparam int unsigned DEF_ADDR_W     = 6;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_JMP,
    OP_CALL,
    OP_RET,
    OP_INC
  } op_e;

  // Pointer must represent 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    if (depth < 1) return 1;
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: DEPTH entries of ADDR_W bits, async-reset pointer, unreset storage.
// Push is ignored when full, pop when empty; push wins if both are requested.
module pc_ret_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned SP_W  = sp_width(DEPTH);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic [SP_W-1:0]   sp_m1;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SP_W'(DEPTH));

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !push_i && !empty_o;

  assign sp_m1  = sp_q - SP_W'(1);
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_m1);
  assign top_o  = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (do_pop) begin
      sp_d = sp_m1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_stack_seq.sv
// Program counter with start latch, call/return stack and sticky stack error flag.
// Define PC_STACK_SEQ_REL_BRANCH_EN to add the rel input for PC-relative jumps.
module pc_stack_seq
  import pc_stack_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              complete,
  input  logic              w_en,
  input  logic              inc,
  input  logic              call,
  input  logic              ret,
`ifdef PC_STACK_SEQ_REL_BRANCH_EN
  input  logic              rel,
`endif
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] instruction_address,
  output logic              running,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              running_q;
  logic              err_q;
  logic              err_d;
  logic [ADDR_W-1:0] abs_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty;
  logic              stk_full;
  logic              stk_push;
  logic              stk_pop;
  op_e               op;

  assign abs_tgt = data_in[ADDR_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);

`ifdef PC_STACK_SEQ_REL_BRANCH_EN
  assign jmp_tgt = rel ? (pc_q + abs_tgt) : abs_tgt;
`else
  assign jmp_tgt = abs_tgt;
`endif

  if (DATA_W > ADDR_W) begin : g_data_hi
    logic data_hi_unused;
    assign data_hi_unused = ^data_in[DATA_W-1:ADDR_W];
  end

  // Ops only act once the latch was already set, and never while complete is high.
  always_comb begin
    op = OP_HOLD;
    if (running_q && !complete) begin
      if (w_en) begin
        op = OP_JMP;
      end else if (call) begin
        op = OP_CALL;
      end else if (ret) begin
        op = OP_RET;
      end else if (inc) begin
        op = OP_INC;
      end
    end
  end

  always_comb begin
    pc_d     = pc_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    unique case (op)
      OP_JMP: pc_d = jmp_tgt;
      OP_CALL: begin
        if (stk_full) begin
          err_d = 1'b1;
        end else begin
          stk_push = 1'b1;
          pc_d     = abs_tgt;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          err_d = 1'b1;
        end else begin
          stk_pop = 1'b1;
          pc_d    = stk_top;
        end
      end
      OP_INC:  pc_d = pc_inc;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= ADDR_W'(RESET_ADDR);
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
      if (en) begin
        running_q <= 1'b1;
      end
    end
  end

  pc_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (stk_push),
    .pop_i       (stk_pop),
    .push_data_i (pc_inc),
    .top_o       (stk_top),
    .empty_o     (stk_empty),
    .full_o      (stk_full)
  );

  assign instruction_address = pc_q;
  assign running             = running_q;
  assign stack_empty         = stk_empty;
  assign stack_full          = stk_full;
  assign stack_err           = err_q;

endmodule
